idecode_regfile: RTL and testbench
==================================

Name: idecode_regfile

Overview:
Decode stage placed directly downstream of the instruction fetch unit. It consumes the fetched 32-bit instruction and the JAL return address (PC+4). It holds the 32x32 general-purpose register file and supplies two operands plus an extended immediate to the execute unit. It also performs the write-back of ALU results, memory load data, or the JAL link address.

Parameters:
REG_NUM, 32, number of architectural registers (index width = clog2(REG_NUM)).
DATA_W, 32, register and datapath width in bits.

Ports:
clock  in  1  system clock; write-back on rising edge (fetch updates PC on falling edge).
reset  in  1  asynchronous, active-low reset.
Instruction  in  32  current instruction from fetch.
opcplus4  in  32  PC+4 from fetch, link value for JAL.
ALU_result  in  32  execute-unit result.
read_data  in  32  load data from data memory / IO.
Jal  in  1  control: JAL in progress.
RegWrite  in  1  control: write-back enable.
MemtoReg  in  1  control: 1 = write read_data, 0 = write ALU_result.
RegDst  in  1  control: 1 = rd (bits 15:11), 0 = rt (bits 20:16).
Read_data_1  out  32  value of rs (bits 25:21).
Read_data_2  out  32  value of rt (bits 20:16).
Sign_extend  out  32  extended immediate (bits 15:0).
dbg_sel  in  5  debug register index.
dbg_data  out  32  value of register dbg_sel, for board display.

Behaviour:
- Reset (reset=0, asynchronous): all registers are cleared to 0 immediately, regardless of clock. All combinational outputs then reflect zeros; Sign_extend still follows Instruction.
- Reads are combinational, with zero latency: Read_data_1 = R[rs], Read_data_2 = R[rt], dbg_data = R[dbg_sel].
- Register 0 always reads 0.
- There is no write-to-read bypass. In the cycle in which a register is being written, reads return the old value until the rising edge; the new value is visible after the edge.
- Destination select (priority order):
  - Jal=1 -> index 31.
  - else RegDst=1 -> rd.
  - else rt.
- Write data select (priority order):
  - Jal=1 -> opcplus4.
  - else MemtoReg=1 -> read_data.
  - else ALU_result.
- Write commit: on the rising clock edge, R[dest] <= wdata when (RegWrite | Jal) and dest != 0.
  - Writes to index 0 are silently discarded.
  - Jal writes even if RegWrite=0.
- Immediate extension, by opcode (bits 31:26):
  - 0x0C (andi), 0x0D (ori), 0x0E (xori), 0x0B (sltiu) -> zero-extend.
  - All other opcodes -> sign-extend bit 15.
- Simultaneous events:
  - reset low during a write edge -> reset wins; the register stays 0.
  - reset released coincident with a clock edge -> no write on that edge is guaranteed. The first guaranteed write is on the next edge.
- Control inputs with X/undefined values while RegWrite=0 and Jal=0 must not alter state.

Decomposition:
- Shared package minisys_pkg holds:
  - opcode constants (OP_RTYPE=0x00, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU, OP_JAL=0x03);
  - field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO, IMM_HI/LO);
  - LINK_REG=31.
- One natural sub-module, regfile_2r1w: the storage array with two read ports, one debug read port, and one write port, plus the async reset and zero-register rule.
- Destination/data muxing and immediate extension stay in idecode_regfile.

Test Plan:
1. Reset: drive reset=0 mid-simulation, after R5 was written to 0x12345678. Response: R5 and dbg_data (dbg_sel=5) read 0 immediately, without waiting for a clock edge.
2. R-type write-back: Instruction=0x00A62020 (add $4,$5,$6), RegDst=1, RegWrite=1, MemtoReg=0, ALU_result=0xDEADBEEF. Response: after the rising edge, R4=0xDEADBEEF. Before the edge, Read_data_1/2 show the old R5/R6.
3. Load write-back: lw with rt=7, RegDst=0, MemtoReg=1, read_data=0x0000ABCD. Response: R7=0x0000ABCD and no other register changes.
4. JAL link: Jal=1, RegWrite=0, opcplus4=0x00000104. Response: R31=0x00000104 after the edge.
5. Register 0 protection: write 0xFFFFFFFF with destination rd=0. Response: Read_data_1 with rs=0 stays 0x00000000.
6. Immediate extension:
   - Instruction imm=0x8001 with opcode 0x08 (addi) -> Sign_extend=0xFFFF8001.
   - Same imm with opcode 0x0D (ori) -> Sign_extend=0x00008001.

Source files
------------

// File: rtl/minisys_pkg.sv
// Shared definitions for the decode stage: opcode constants, instruction
// field bit positions, the link register index and the immediate-extension
// rule.
package minisys_pkg;

  // Opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // Instruction field positions
  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  // JAL writes its return address here
  localparam int unsigned LINK_REG = 31;

  // Logical immediates and sltiu take an unsigned (zero-extended) immediate;
  // everything else sign-extends.
  function automatic logic imm_zero_ext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) ||
           (opcode == OP_XORI) || (opcode == OP_SLTIU);
  endfunction

endpackage

// File: rtl/idecode_regfile_regfile.sv
// regfile_2r1w: general-purpose register storage.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   raddr1/rdata1         read port 1 (combinational)
//   raddr2/rdata2         read port 2 (combinational)
//   dbg_addr/dbg_rdata    debug read port (combinational)
//   wen, waddr, wdata     single write port, committed on the rising edge
// Register 0 is hardwired to zero; writes to it are discarded. Reads never
// bypass a same-cycle write.
module regfile_2r1w
  #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned AW      = $clog2(REG_NUM)
  )
  (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
  );

  logic [DATA_W-1:0] mem [REG_NUM];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1    = (raddr1   == '0) ? '0 : mem[raddr1];
    rdata2    = (raddr2   == '0) ? '0 : mem[raddr2];
    dbg_rdata = (dbg_addr == '0) ? '0 : mem[dbg_addr];
  end

endmodule

// File: rtl/idecode_regfile.sv
// idecode_regfile: instruction decode stage.
// Ports:
//   clock, reset          write-back clock (rising edge), async active-low reset
//   Instruction           fetched instruction
//   opcplus4              PC+4, link value for JAL
//   ALU_result            execute result for write-back
//   read_data             memory/IO load data for write-back
//   Jal, RegWrite,
//   MemtoReg, RegDst      write-back control
//   Read_data_1/2         R[rs], R[rt]
//   Sign_extend           extended 16-bit immediate
//   dbg_sel, dbg_data     debug register read for board display
// Chooses write-back destination and data, extends the immediate, and holds
// the register file.
module idecode_regfile
  import minisys_pkg::*;
  #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned DATA_W  = 32
  )
  (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       Instruction,
    input  logic [DATA_W-1:0] opcplus4,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic              Jal,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              RegDst,
    output logic [DATA_W-1:0] Read_data_1,
    output logic [DATA_W-1:0] Read_data_2,
    output logic [DATA_W-1:0] Sign_extend,
    input  logic [4:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
  );

  localparam int unsigned AW = $clog2(REG_NUM);

  logic [5:0]        opcode;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [AW-1:0]     rd;
  logic [15:0]       imm;
  logic [AW-1:0]     dest;
  logic [DATA_W-1:0] wdata;
  logic              wen;

  always_comb begin
    opcode = Instruction[OP_HI:OP_LO];
    rs     = AW'(Instruction[RS_HI:RS_LO]);
    rt     = AW'(Instruction[RT_HI:RT_LO]);
    rd     = AW'(Instruction[RD_HI:RD_LO]);
    imm    = Instruction[IMM_HI:IMM_LO];
  end

  // Destination and data priority: Jal overrides everything else.
  always_comb begin
    dest  = rt;
    wdata = ALU_result;
    if (Jal) begin
      dest  = AW'(LINK_REG);
      wdata = opcplus4;
    end else begin
      if (RegDst) dest = rd;
      if (MemtoReg) wdata = read_data;
    end
  end

  // Jal writes regardless of RegWrite; with both low the mux selects are
  // don't-care because no write is enabled.
  assign wen = RegWrite | Jal;

  always_comb begin
    if (imm_zero_ext(opcode)) begin
      Sign_extend = {{(DATA_W-16){1'b0}}, imm};
    end else begin
      Sign_extend = {{(DATA_W-16){imm[15]}}, imm};
    end
  end

  regfile_2r1w #(
    .REG_NUM (REG_NUM),
    .DATA_W  (DATA_W),
    .AW      (AW)
  ) u_regs (
    .clock     (clock),
    .reset     (reset),
    .raddr1    (rs),
    .rdata1    (Read_data_1),
    .raddr2    (rt),
    .rdata2    (Read_data_2),
    .dbg_addr  (AW'(dbg_sel)),
    .dbg_rdata (dbg_data),
    .wen       (wen),
    .waddr     (dest),
    .wdata     (wdata)
  );

endmodule

// File: tb/tb_idecode_regfile.sv
// Self-checking bench for idecode_regfile: directed scenarios plus
// randomized traffic against an array model of the register file.
module tb_idecode_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic [31:0] alu;
  logic [31:0] rdata;
  logic        jal;
  logic        regwrite;
  logic        memtoreg;
  logic        regdst;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] sext;
  logic [4:0]  dsel;
  logic [31:0] ddata;

  int checks;
  int errors;
  logic [31:0] model [32];

  idecode_regfile #(.REG_NUM(32), .DATA_W(32)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .Instruction (instr),
    .opcplus4    (pc4),
    .ALU_result  (alu),
    .read_data   (rdata),
    .Jal         (jal),
    .RegWrite    (regwrite),
    .MemtoReg    (memtoreg),
    .RegDst      (regdst),
    .Read_data_1 (rd1),
    .Read_data_2 (rd2),
    .Sign_extend (sext),
    .dbg_sel     (dsel),
    .dbg_data    (ddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] ins);
    int unsigned op;
    int unsigned im;
    op = ins >> 26;
    im = ins & 32'hFFFF;
    if (op == 12 || op == 13 || op == 14 || op == 11) return im;
    if (im >= 32768) return im + 32'hFFFF0000;
    return im;
  endfunction

  function automatic int unsigned fld(input logic [31:0] ins, input int unsigned lo);
    return (ins >> lo) & 31;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic compare_all();
    chk("read_data_1", rd1, model[fld(instr, 21)]);
    chk("read_data_2", rd2, model[fld(instr, 16)]);
    chk("dbg_data", ddata, model[dsel]);
    chk("sign_extend", sext, ext_model(instr));
  endtask

  // Check outputs before the edge, then apply the write-back rule to the model.
  task automatic cycle();
    int unsigned dst;
    logic [31:0] wv;
    logic        do_wr;
    #1;
    compare_all();
    do_wr = jal || regwrite;
    if (jal) begin
      dst = 31; wv = pc4;
    end else begin
      dst = regdst ? fld(instr, 11) : fld(instr, 16);
      wv  = memtoreg ? rdata : alu;
    end
    @(posedge clk);
    if (rst_n && do_wr && dst != 0) model[dst] = wv;
    #1;
  endtask

  task automatic idle();
    jal = 0; regwrite = 0; memtoreg = 0; regdst = 0;
  endtask

  task automatic wr_reg(input logic [4:0] idx, input logic [31:0] val);
    instr = {6'h00, 5'd0, 5'd0, idx, 11'h020};
    jal = 0; regwrite = 1; memtoreg = 0; regdst = 1; alu = val;
    cycle();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 0;
    instr = '0; pc4 = '0; alu = '0; rdata = '0; dsel = '0;
    idle();
    #2;
    dsel = 5'd31;
    instr = 32'h03E0F820;
    #1;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_dbg", ddata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // R-type write-back (add $4,$5,$6)
    wr_reg(5'd5, 32'h12345678);
    wr_reg(5'd6, 32'h0BADF00D);
    instr = 32'h00A62020; regdst = 1; regwrite = 1; memtoreg = 0; alu = 32'hDEADBEEF;
    dsel = 5'd4;
    #1;
    chk("add_pre_rs", rd1, 32'h12345678);
    chk("add_pre_rt", rd2, 32'h0BADF00D);
    chk("add_pre_r4", ddata, 32'h0);
    cycle();
    chk("add_r4", ddata, 32'hDEADBEEF);
    idle();

    // Load write-back: lw $7, 0($0)
    instr = 32'h8C070000; regdst = 0; memtoreg = 1; regwrite = 1;
    rdata = 32'h0000ABCD; alu = 32'h55555555; dsel = 5'd7;
    cycle();
    chk("lw_r7", ddata, 32'h0000ABCD);
    idle();
    for (int i = 0; i < 32; i++) begin
      dsel = 5'(i);
      #1;
      chk("lw_others", ddata, model[i]);
    end

    // JAL link with RegWrite low
    instr = 32'h0C000040; jal = 1; regwrite = 0; pc4 = 32'h00000104; dsel = 5'd31;
    cycle();
    chk("jal_r31", ddata, 32'h00000104);
    idle();

    // Register 0 protection
    wr_reg(5'd0, 32'hFFFFFFFF);
    instr = 32'h00000020;
    #1;
    chk("r0_read", rd1, 32'h0);

    // Immediate extension
    instr = 32'h20008001;
    #1;
    chk("sext_addi", sext, 32'hFFFF8001);
    instr = 32'h34008001;
    #1;
    chk("zext_ori", sext, 32'h00008001);

    // Both enables low: other controls must not matter
    instr = 32'h00E7F820; jal = 0; regwrite = 0; regdst = 1; memtoreg = 1;
    alu = 32'h11111111; rdata = 32'h22222222;
    cycle();
    idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) == 0) instr[31:26] = 6'($urandom_range(11, 14));
      pc4      = $urandom;
      alu      = $urandom;
      rdata    = $urandom;
      jal      = ($urandom_range(0, 7) == 0);
      regwrite = $urandom_range(0, 1);
      memtoreg = $urandom_range(0, 1);
      regdst   = $urandom_range(0, 1);
      dsel     = 5'($urandom_range(0, 31));
      cycle();
    end
    idle();

    // Asynchronous reset mid-simulation
    wr_reg(5'd5, 32'h12345678);
    dsel = 5'd5;
    instr = 32'h00A00000;
    #1;
    chk("pre_reset_r5", ddata, 32'h12345678);
    #2;
    rst_n = 0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    chk("async_reset_dbg", ddata, 32'h0);
    chk("async_reset_rd1", rd1, 32'h0);

    // Write attempted while reset is held: must be lost
    instr = {6'h00, 5'd0, 5'd0, 5'd9, 11'h020};
    regdst = 1; regwrite = 1; alu = 32'hCAFEBABE; dsel = 5'd9;
    @(posedge clk);
    #1;
    chk("reset_blocks_write", ddata, 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 50; n++) begin
      instr    = $urandom;
      alu      = $urandom;
      rdata    = $urandom;
      pc4      = $urandom;
      jal      = ($urandom_range(0, 7) == 0);
      regwrite = $urandom_range(0, 1);
      memtoreg = $urandom_range(0, 1);
      regdst   = $urandom_range(0, 1);
      dsel     = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
